// File: rtl/tick_timer.sv
// tick_timer: programmable 16-bit interval timer clocked by clkin.
// It counts rising edges of tick_in (the divided 1 MHz clock) and raises a
// maskable interrupt on expiry. Four byte-wide registers are accessed over a
// cs/wr/rd bus.
// The optional square-wave output port tout is present only when the macro
// TICK_TIMER_OUT_EN is defined.
module tick_timer #(
    parameter logic [15:0] RESET_LATCH = 16'hFFFF,
    parameter int unsigned TICK_SYNC   = 0
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
`ifdef TICK_TIMER_OUT_EN
    ,
    output logic       tout
`endif
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] latch;
    logic [2:0]  ctrl;
    logic        flag;
    logic [7:0]  hold;

    logic        tick_s;
    logic        tick_d;
    logic        tick;
    logic        wr_en;
    logic        rd_en;
    logic        load;
    logic        cnt_tick;
    logic        expire;

    generate
        if (TICK_SYNC != 0) begin : g_sync
            logic [1:0] sync_q;
            // Two-flop synchronizer for a tick_in from a foreign clock domain
            always_ff @(posedge clkin or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], tick_in};
                end
            end
            assign tick_s = sync_q[1];
        end else begin : g_nosync
            assign tick_s = tick_in;
        end
    endgenerate

    // Delayed copy of the tick source for rising-edge detection
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_s;
        end
    end

    // Bus strobes and count qualification; a counter reload drops a coincident tick
    always_comb begin
        tick     = tick_s & ~tick_d;
        wr_en    = cs & wr;
        rd_en    = cs & rd;
        load     = wr_en && (addr == 2'd1);
        cnt_tick = (state == RUNNING) && ctrl[0] && tick && !load;
        expire   = cnt_tick && (count == '0);
    end

    // Register file, read port and counter FSM
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= STOPPED;
            count <= '0;
            latch <= RESET_LATCH;
            ctrl  <= '0;
            flag  <= 1'b0;
            hold  <= '0;
            dout  <= '0;
`ifdef TICK_TIMER_OUT_EN
            tout  <= 1'b0;
`endif
        end else begin
            if (rd_en) begin
                case (addr)
                    2'd0: begin
                        dout <= count[7:0];
                        hold <= count[15:8];
                    end
                    2'd1: dout <= hold;
                    2'd2: dout <= {5'b0, ctrl};
                    default: begin
                        dout <= {7'b0, flag};
                        flag <= 1'b0;
                    end
                endcase
            end

            if (wr_en) begin
                case (addr)
                    2'd0:    latch[7:0]  <= din;
                    2'd1:    latch[15:8] <= din;
                    2'd2:    ctrl        <= din[2:0];
                    default: ;
                endcase
            end

            // Later assignments override the status-read clear, so an expiry in
            // the same cycle as a status read leaves the flag set.
            if (load) begin
                count <= {din, latch[7:0]};
                flag  <= 1'b0;
                state <= RUNNING;
            end else if (expire) begin
                flag <= 1'b1;
`ifdef TICK_TIMER_OUT_EN
                tout <= ~tout;
`endif
                if (ctrl[1]) begin
                    count <= latch;
                end else begin
                    state <= STOPPED;
                end
            end else if (cnt_tick) begin
                count <= count - 16'd1;
            end
        end
    end

    assign irq = flag & ctrl[2];

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: self-checking bench for tick_timer.
// Two instances share all inputs: TICK_SYNC=0 (index 0) and TICK_SYNC=1 (index 1).
// A behavioural model predicts dout/irq for both on every cycle. Directed
// sequences add literal expectations on instance 0.
module tb_tick_timer;

    localparam logic [15:0] RL = 16'hFFFF;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       cs = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout0, dout1;
    logic       irq0, irq1;
`ifdef TICK_TIMER_OUT_EN
    logic       tout0, tout1;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          chk_en = 1'b0;

    tick_timer #(.RESET_LATCH(RL), .TICK_SYNC(0)) dut0 (
        .clkin(clkin), .reset(reset), .tick_in(tick_in), .cs(cs), .wr(wr), .rd(rd),
        .addr(addr), .din(din), .dout(dout0), .irq(irq0)
`ifdef TICK_TIMER_OUT_EN
        , .tout(tout0)
`endif
    );

    tick_timer #(.RESET_LATCH(RL), .TICK_SYNC(1)) dut1 (
        .clkin(clkin), .reset(reset), .tick_in(tick_in), .cs(cs), .wr(wr), .rd(rd),
        .addr(addr), .din(din), .dout(dout1), .irq(irq1)
`ifdef TICK_TIMER_OUT_EN
        , .tout(tout1)
`endif
    );

    always #5 clkin = ~clkin;

    function automatic void check(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int unsigned m_count[2], m_latch[2], m_ctrl[2], m_hold[2], m_dout[2];
    bit          m_run[2], m_flag[2], m_tout[2];
    bit          h[3];   // h[j]: tick_in sampled j+1 edges ago
    bit          tk0, tk1;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_latch[k] = RL; m_ctrl[k] = 0; m_hold[k] = 0;
            m_dout[k] = 0; m_run[k] = 0; m_flag[k] = 0; m_tout[k] = 0;
        end
        for (int j = 0; j < 3; j++) h[j] = 0;
    endtask

    task automatic model_step(input int k, input bit tk);
        bit          w, r, reload, expire, en, cont;
        int unsigned c, old_latch;
        w = cs && wr;
        r = cs && rd;
        reload = w && (addr == 2'd1);
        c = m_count[k];
        old_latch = m_latch[k];
        en = (m_ctrl[k] & 1) != 0;
        cont = (m_ctrl[k] & 2) != 0;
        expire = m_run[k] && en && tk && !reload && (c == 0);
        if (r) begin
            if (addr == 2'd0) begin m_dout[k] = c % 256; m_hold[k] = c / 256; end
            else if (addr == 2'd1) m_dout[k] = m_hold[k];
            else if (addr == 2'd2) m_dout[k] = m_ctrl[k];
            else begin m_dout[k] = m_flag[k]; m_flag[k] = 0; end
        end
        if (w) begin
            if (addr == 2'd0) m_latch[k] = (old_latch / 256) * 256 + din;
            else if (addr == 2'd1) m_latch[k] = din * 256 + (old_latch % 256);
            else if (addr == 2'd2) m_ctrl[k] = din % 8;
        end
        if (reload) begin
            m_count[k] = din * 256 + (old_latch % 256);
            m_flag[k] = 0;
            m_run[k] = 1;
        end else if (expire) begin
            m_flag[k] = 1;
            m_tout[k] = !m_tout[k];
            if (cont) m_count[k] = old_latch;
            else m_run[k] = 0;
        end else if (m_run[k] && en && tk) begin
            m_count[k] = c - 1;
        end
    endtask

    initial model_reset();

    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            tk0 = tick_in && !h[0];
            tk1 = h[1] && !h[2];
            h[2] = h[1]; h[1] = h[0]; h[0] = tick_in;
            model_step(0, tk0);
            model_step(1, tk1);
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clkin) begin
        if (chk_en) begin
            check("dout_sync0", dout0, m_dout[0]);
            check("irq_sync0", irq0, (m_flag[0] && (m_ctrl[0] & 4) != 0) ? 1 : 0);
            check("dout_sync1", dout1, m_dout[1]);
            check("irq_sync1", irq1, (m_flag[1] && (m_ctrl[1] & 4) != 0) ? 1 : 0);
`ifdef TICK_TIMER_OUT_EN
            check("tout_sync0", tout0, m_tout[0]);
            check("tout_sync1", tout1, m_tout[1]);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1; wr = 1; addr = a; din = d;
        cyc();
        cs = 0; wr = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        cs = 1; rd = 1; addr = a;
        cyc();
        cs = 0; rd = 0;
        d = dout0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1; repeat (4) cyc();
            tick_in = 0; repeat (4) cyc();
        end
    endtask

    logic [7:0] rv;

    initial begin
        // Reset held with tick_in toggling
        for (int i = 0; i < 12; i++) begin
            tick_in = (i % 8) < 4;
            cyc();
            chk_en = 1;
        end
        check("rst_dout", dout0, 0);
        check("rst_irq", irq0, 0);
        reset = 0; tick_in = 0;
        cyc();
        bus_rd(2'd0, rv); check("rst_count", rv, 8'h00);
        bus_rd(2'd2, rv); check("rst_ctrl", rv, 8'h00);

        // Continuous mode, latch 3
        bus_wr(2'd2, 8'h07);
        bus_wr(2'd0, 8'h03);
        bus_wr(2'd1, 8'h00);
        ticks(1);
        bus_rd(2'd0, rv); check("cont_cnt2", rv, 8'h02);
        ticks(2);
        bus_rd(2'd0, rv); check("cont_cnt0", rv, 8'h00);
        check("cont_noirq", irq0, 0);
        ticks(1);
        check("cont_irq", irq0, 1);
        bus_rd(2'd0, rv); check("cont_reload", rv, 8'h03);
        bus_rd(2'd3, rv); check("stat_set", rv, 8'h01);
        check("stat_irq_clr", irq0, 0);
        bus_rd(2'd3, rv); check("stat_clr", rv, 8'h00);

        // Status read coinciding with expiry
        ticks(3);
        tick_in = 1; cs = 1; rd = 1; addr = 2'd3;
        cyc();
        cs = 0; rd = 0;
        check("stat_race_rd", dout0, 8'h00);
        check("stat_race_irq", irq0, 1);
        repeat (3) cyc();
        tick_in = 0; repeat (4) cyc();
        bus_rd(2'd3, rv); check("stat_race_flag", rv, 8'h01);

        // One-shot, latch 2
        bus_wr(2'd2, 8'h05);
        bus_wr(2'd0, 8'h02);
        bus_wr(2'd1, 8'h00);
        ticks(3);
        check("os_irq", irq0, 1);
        bus_rd(2'd0, rv); check("os_cnt0", rv, 8'h00);
        ticks(10);
        bus_rd(2'd0, rv); check("os_stopped", rv, 8'h00);
        bus_rd(2'd3, rv); check("os_flag", rv, 8'h01);
        bus_wr(2'd1, 8'h00);
        ticks(1);
        bus_rd(2'd0, rv); check("os_restart", rv, 8'h01);

        // Hold register snapshot
        bus_wr(2'd0, 8'h34);
        bus_wr(2'd1, 8'h12);
        bus_rd(2'd0, rv); check("hold_lo", rv, 8'h34);
        ticks(300);
        bus_rd(2'd1, rv); check("hold_hi", rv, 8'h12);
        bus_rd(2'd0, rv); check("live_lo", rv, 8'h08);
        bus_rd(2'd1, rv); check("live_hi", rv, 8'h11);

        // Reload coincident with a tick edge: tick dropped
        tick_in = 1; cs = 1; wr = 1; addr = 2'd1; din = 8'h00;
        cyc();
        cs = 0; wr = 0;
        repeat (3) cyc();
        tick_in = 0; repeat (4) cyc();
        bus_rd(2'd0, rv); check("load_race", rv, 8'h34);
        ticks(1);
        bus_rd(2'd0, rv); check("load_dec", rv, 8'h33);

        // EN=0 ignores ticks
        bus_wr(2'd2, 8'h04);
        ticks(2);
        bus_rd(2'd0, rv); check("en_off", rv, 8'h33);
        bus_rd(2'd2, rv); check("ctrl_rd", rv, 8'h04);

        // Reset mid-count, then reset latch value
        bus_wr(2'd2, 8'h07);
        tick_in = 1; cyc();
        reset = 1;
        repeat (3) cyc();
        tick_in = 0;
        repeat (3) cyc();
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_irq", irq0, 0);
        reset = 0;
        cyc();
        bus_rd(2'd0, rv); check("mid_rst_cnt", rv, 8'h00);
        bus_wr(2'd1, 8'h00);
        bus_rd(2'd0, rv); check("rst_latch", rv, 8'hFF);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            int unsigned op;
            if ($urandom_range(0, 699) == 0) begin
                reset = 1;
                repeat ($urandom_range(1, 3)) cyc();
                reset = 0;
            end
            tick_in = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : ((i % 8) < 4);
            op = $urandom_range(0, 15);
            cs = 0; wr = 0; rd = 0;
            addr = 2'($urandom_range(0, 3));
            if (op < 3) begin
                cs = 1; wr = 1;
                if (addr == 2'd0) din = 8'($urandom_range(0, 7));
                else if (addr == 2'd1) din = 8'($urandom_range(0, 1));
                else din = 8'($urandom);
            end else if (op < 6) begin
                cs = 1; rd = 1;
            end else begin
                cs = ($urandom_range(0, 3) == 0);
                din = 8'($urandom);
            end
            cyc();
            cs = 0; wr = 0; rd = 0;
        end

        cyc();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
